// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared sizing constants for the architectural register file. The decode
// stage imports this package as well so register index widths stay in step.
//   DATA_W   : register width in bits
//   NUM_REGS : number of architectural registers (including the zero register)
//   ADDR_W   : register index width
//   ZERO_REG : index of the hardwired-zero register (no storage behind it)
package regfile_pkg;

    localparam int DATA_W   = 64;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/decoder_5to32.sv
// decoder_5to32
// Gate-level 5-to-32 one-hot decoder with enable. Output y[i] is high only
// when en is high and a equals i.
//   en : input  1  decoder enable
//   a  : input  5  index to decode
//   y  : output 32 one-hot decoded enables (all zero when en is low)
module decoder_5to32 (
    input  logic        en,
    input  logic [4:0]  a,
    output logic [31:0] y
);

    // Each output is an AND of the enable with five XNOR terms, one per index
    // bit, so the structure maps directly onto primitive gates.
    for (genvar i = 0; i < 32; i++) begin : g_out
        localparam logic [4:0] IDX = 5'(i);
        assign y[i] = en & (&(a ~^ IDX));
    end

endmodule

// File: rtl/regfile.sv
// regfile
// Architectural register file: 32 x 64-bit, two asynchronous read ports,
// one synchronous write port, X31 hardwired to zero, and a same-cycle
// write-to-read bypass so decode sees the value write-back is committing.
//   clk           : input  1   clock, all state updates on posedge
//   reset         : input  1   synchronous active-high clear of all registers
//   RegWrite      : input  1   write enable from write-back
//   WriteRegister : input  5   write index
//   WriteData     : input  64  write value
//   ReadRegister1 : input  5   read port 1 index
//   ReadRegister2 : input  5   read port 2 index
//   ReadData1     : output 64  read port 1 data (bypassed)
//   ReadData2     : output 64  read port 2 data (bypassed)
module regfile
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    logic [NUM_REGS-1:0] dec_en;
    logic                wr_live;
    logic                byp1;
    logic                byp2;

    // Only entries 0..30 have storage; X31 reads as zero via the mux tree.
    logic [DATA_W-1:0] regs [0:NUM_REGS-2];

    // Heap-ordered mux trees: node 1 is the root, nodes NUM_REGS..2*NUM_REGS-1
    // are the leaves (register k sits at node NUM_REGS+k).
    logic [DATA_W-1:0] tree1 [1:2*NUM_REGS-1];
    logic [DATA_W-1:0] tree2 [1:2*NUM_REGS-1];

    decoder_5to32 u_write_dec (
        .en (RegWrite),
        .a  (WriteRegister),
        .y  (dec_en)
    );

    // The decoder's X31 output flags a write aimed at the zero register.
    // Such a write has no storage to land in and must not bypass either, so
    // it is folded out of the live-write qualifier here.
    assign wr_live = RegWrite & ~dec_en[ZERO_REG];

    // Storage update. Reset wins over a simultaneous write, dropping it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                if (dec_en[i]) begin
                    regs[i] <= WriteData;
                end
            end
        end
    end

    // Leaves: stored registers, with the zero register tied off at the input.
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_leaf
        if (k == int'(ZERO_REG)) begin : g_zero
            assign tree1[NUM_REGS+k] = '0;
            assign tree2[NUM_REGS+k] = '0;
        end else begin : g_reg
            assign tree1[NUM_REGS+k] = regs[k];
            assign tree2[NUM_REGS+k] = regs[k];
        end
    end

    // Five levels of 2:1 muxes; the root level is steered by the index MSB.
    for (genvar d = 0; d < ADDR_W; d++) begin : g_level
        for (genvar j = 0; j < (1 << d); j++) begin : g_node
            localparam int N = (1 << d) + j;
            assign tree1[N] = ReadRegister1[ADDR_W-1-d] ? tree1[2*N+1] : tree1[2*N];
            assign tree2[N] = ReadRegister2[ADDR_W-1-d] ? tree2[2*N+1] : tree2[2*N];
        end
    end

    // Final bypass mux per port: a live write to the same index forwards the
    // incoming data regardless of reset, since reset only affects storage.
    assign byp1 = wr_live & (WriteRegister == ReadRegister1);
    assign byp2 = wr_live & (WriteRegister == ReadRegister2);

    assign ReadData1 = byp1 ? WriteData : tree1[1];
    assign ReadData2 = byp2 ? WriteData : tree2[1];

endmodule

// File: tb/tb_regfile.sv
// tb_regfile
// Directed scoreboard bench for regfile. Each stimulus step pushes the
// hand-computed read-port values into a queue and raises a sample event; a
// separate monitor pops each entry and compares it with both read ports.
module tb_regfile;
    import regfile_pkg::*;

    typedef struct {
        string       name;
        logic [63:0] exp1;
        logic [63:0] exp2;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;

    exp_t sb[$];
    event sample_ev;
    int   check_count;
    int   pass_count;
    bit   stim_done;

    regfile dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge, let the combinational
    // read path settle, then hand the expected pre-edge values to the monitor.
    task automatic applyStimulus(input logic rst, input logic we, input logic [4:0] wa,
                                 input logic [63:0] wd, input logic [4:0] r1,
                                 input logic [4:0] r2, input string name,
                                 input logic [63:0] e1, input logic [63:0] e2);
        exp_t e;
        @(negedge clk);
        reset         = rst;
        RegWrite      = we;
        WriteRegister = wa;
        WriteData     = wd;
        ReadRegister1 = r1;
        ReadRegister2 = r2;
        #2;
        e.name = name;
        e.exp1 = e1;
        e.exp2 = e2;
        sb.push_back(e);
        ->sample_ev;
    endtask

    // One comparison: bumps the counters and reports a mismatch.
    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        check_count++;
        if (act === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Monitor: whenever a sample is presented, pop the matching expectation.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            if (sb.size() == 0) begin
                check_count++;
                $display("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
            end else begin
                e = sb.pop_front();
                checkOutput({e.name, "_rd1"}, ReadData1, e.exp1);
                checkOutput({e.name, "_rd2"}, ReadData2, e.exp2);
            end
        end
    end

    // Directed stimulus.
    initial begin
        check_count   = 0;
        pass_count    = 0;
        stim_done     = 1'b0;
        reset         = 1'b1;
        RegWrite      = 1'b0;
        WriteRegister = 5'd0;
        WriteData     = 64'h0;
        ReadRegister1 = 5'd0;
        ReadRegister2 = 5'd0;
        repeat (2) @(posedge clk);

        // After reset every index reads zero on both ports.
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 5'(i), 5'(31 - i),
                          $sformatf("reset_read_%0d", i), 64'h0, 64'h0);
        end

        // Write X5, bypass visible in the write cycle, stored value afterwards.
        applyStimulus(1'b0, 1'b1, 5'd5, 64'hDEAD_BEEF_0000_0005, 5'd5, 5'd4,
                      "x5_bypass", 64'hDEAD_BEEF_0000_0005, 64'h0);
        applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 5'd5, 5'd4,
                      "x5_stored", 64'hDEAD_BEEF_0000_0005, 64'h0);

        // Disabled writes to X7 leave it at zero.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 5'd7, 64'h1234, 5'd7, 5'd7,
                          $sformatf("x7_nowrite_%0d", i), 64'h0, 64'h0);
        end
        applyStimulus(1'b0, 1'b1, 5'd7, 64'h1234, 5'd7, 5'd7,
                      "x7_write", 64'h1234, 64'h1234);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 5'd7, 64'h9999, 5'd7, 5'd5,
                          $sformatf("x7_hold_%0d", i), 64'h1234, 64'hDEAD_BEEF_0000_0005);
        end

        // Writes to X31 neither bypass nor store.
        applyStimulus(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd5,
                      "x31_write", 64'h0, 64'hDEAD_BEEF_0000_0005);
        applyStimulus(1'b0, 1'b0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31,
                      "x31_after", 64'h0, 64'h0);

        // Both ports bypass the same index, then read it from storage.
        applyStimulus(1'b0, 1'b1, 5'd9, 64'hABCD, 5'd9, 5'd9,
                      "x9_bypass", 64'hABCD, 64'hABCD);
        applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 5'd9, 5'd9,
                      "x9_stored", 64'hABCD, 64'hABCD);

        // Independent ports: one bypassing, one reading storage.
        applyStimulus(1'b0, 1'b1, 5'd10, 64'hA, 5'd10, 5'd7,
                      "x10_bypass", 64'hA, 64'h1234);

        // Write during reset: bypass still shows the in-flight value, but the
        // store is dropped and every register is cleared.
        applyStimulus(1'b1, 1'b1, 5'd3, 64'h55, 5'd3, 5'd3,
                      "x3_reset_bypass", 64'h55, 64'h55);
        applyStimulus(1'b0, 1'b1, 5'd3, 64'h66, 5'd3, 5'd5,
                      "x3_post_reset_write", 64'h66, 64'h0);
        applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 5'd3, 5'd7,
                      "x3_stored", 64'h66, 64'h0);
        applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 5'd9, 5'd10,
                      "cleared_regs", 64'h0, 64'h0);

        stim_done = 1'b1;
    end

    // Wrap-up: wait (bounded) for stimulus and scoreboard to drain.
    initial begin
        int cycles;
        cycles = 0;
        while (!(stim_done && sb.size() == 0) && cycles < 2000) begin
            @(posedge clk);
            cycles++;
        end
        if (!(stim_done && sb.size() == 0)) begin
            check_count++;
            $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/regfile.md
# regfile

Architectural register file for the pipelined 64-bit CPU: 32 × 64-bit registers, two asynchronous read ports, one synchronous write port. X31 is hardwired to zero. Same-cycle write-to-read bypass lets the decode stage read a value the write-back stage is committing in the same cycle. Sits between write-back (feeds the write port) and decode (consumes the read ports); storage is one 64-bit enabled register per entry.

## Interface
Parameters (fixed; taken from package, not overridable):
- DATA_W, 64, register width
- NUM_REGS, 32, register count
- ADDR_W, 5, register index width
- ZERO_REG, 5'd31, hardwired-zero index

Ports:
- clk  input  1  single clock; all state updates on posedge
- reset  input  1  synchronous, active-high; clears every register at posedge clk while high
- RegWrite  input  1  write enable from write-back stage
- WriteRegister  input  5  write index
- WriteData  input  64  write value
- ReadRegister1  input  5  read port 1 index
- ReadRegister2  input  5  read port 2 index
- ReadData1  output  64  read port 1 data
- ReadData2  output  64  read port 2 data

## Operation
- Storage: entries 0..30 are 64-bit registers with individual write enables. Entry 31 has no storage; it reads as 64'h0.
- Write decode: 5→32 decoder gated by RegWrite; exactly one enable is high when RegWrite=1 and WriteRegister≠31; none otherwise.
- Write to X31: silently dropped; no state changes.
- Read: ReadDataN = contents[ReadRegisterN] through a 32:1 × 64 mux tree; ReadRegisterN=31 → 0.
- Bypass: if RegWrite=1, WriteRegister==ReadRegisterN and WriteRegister≠31 → ReadDataN = WriteData (combinational, same cycle). Otherwise stored value.
- Both ports are independent; both may hit the same index and/or the bypass at once.
- Reset: at a posedge with reset=1, all 31 registers → 0. Reset takes priority over a simultaneous write, so the written value is lost. With reset held, ReadDataN still shows the bypass value for a matching in-flight write, and 0 otherwise.
- Reset mid-operation: a write pending in the same cycle as reset is dropped. The next write after reset deasserts behaves normally.

## Timing
- Write latency: value present in storage after the posedge at which RegWrite=1. It is visible on the non-bypassed path from that edge onward.
- Read latency: combinational (0 cycles). Gate-level paths use 50 ps per gate primitive.
- Read settle (address change or bypass match → ReadData stable): must complete within half the 100 ps-scaled clock period used by the CPU bench. In practice the mux tree plus bypass mux is ≤ 7 gate levels.
- Reset value of outputs: after the reset edge, ReadData1 = ReadData2 = 0 for any index, absent bypass.
- No handshake; write-back guarantees at most one write per cycle.

## Structure
- Shared package regfile_pkg holds DATA_W, NUM_REGS, ADDR_W and ZERO_REG. The decode stage imports it for index width.
- Sub-module decoder_5to32: gate-level 5-to-32 one-hot decoder with enable. Instantiated once for the write-enable vector.
- The read mux tree is a generate loop of 2:1 gate muxes (5 levels) per port. The bypass is a final 2:1 mux per port, selected by a 5-bit equality compare AND RegWrite AND (WriteRegister≠31).
- Entry 31 is tied to 0 at the mux input; there is no storage instance for it.

## Test plan
- Reset, then read all 32 indices on both ports → every ReadData = 0.
- Write X5=64'hDEAD_BEEF_0000_0005 (RegWrite=1). Next cycle, read X5 on port 1 and X4 on port 2 → 64'hDEAD_BEEF_0000_0005 and 0.
- RegWrite=0 with WriteRegister=7 and WriteData=64'h1234 for 3 cycles → X7 reads 0. Then RegWrite=1 for one cycle → X7 reads 64'h1234 and holds for 5 more cycles.
- Write X31=64'hFFFF_FFFF_FFFF_FFFF → ReadRegister1=31 reads 0 in that cycle (no bypass) and after.
- Same cycle: write X9=64'hABCD with ReadRegister1=ReadRegister2=9 → both ports show 64'hABCD before the edge, then the stored value after it.
- Write X3=64'h55 simultaneously with reset=1 → X3 reads 0 after the edge. A write of 64'h66 in the next cycle with reset=0 → X3 reads 64'h66.
